rr_stream_mux: RTL and testbench

- Parametrised, registered N-to-1 stream multiplexer with round-robin arbitration and valid/ready handshakes on every channel.
- Successor to the combinational 2:1 32-bit mux: generalised in width and channel count, with one output register stage and backpressure.
- Sits between multiple requesters and a single shared consumer in the RV32 core, e.g. instruction/data fetch to a shared memory port, or multiple writeback sources.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/rr_stream_mux.sv | 68 ++++++
 tb/tb_rr_stream_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the round-robin stream mux
package mux_pkg;

    localparam int MUX_DATA_W   = 32;
    localparam int MUX_CHANNELS = 4;

    // Channel index width; a single channel still needs one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter with pointer register
// RR_STREAM_MUX_FIXED_PRIO_EN: search always starts at channel 0, pointer removed
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = MUX_CHANNELS,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_req
);

    logic [SEL_W-1:0] ptr;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
    assign ptr = '0;

    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, advance};
`else
    generate
        if (N == 1) begin : g_single
            assign ptr = '0;

            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, advance};
        end else begin : g_rr
            // Next search starts just after the channel that was served
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr <= '0;
                end else if (advance) begin
                    ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    endgenerate
`endif

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - registered N-to-1 stream mux with round-robin arbitration
// RR_STREAM_MUX_FIXED_PRIO_EN selects fixed lowest-index priority in the arbiter
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = MUX_DATA_W,
    parameter  int N     = MUX_CHANNELS,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel
);

    logic             load;
    logic             advance;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic             any_req;
    logic [WIDTH-1:0] chan_data [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The register can take a beat when empty or when its beat leaves this cycle
    assign load     = !out_valid || out_ready;
    assign advance  = load && any_req && !rst;
    assign in_ready = (load && !rst) ? grant : '0;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= chan_data[grant_idx];
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - randomized and directed checks of rr_stream_mux against a reference model
module tb_rr_stream_mux;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;

    logic [W-1:0] ch [N];

    int total = 0;
    int bad   = 0;

    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_sel   = 0;
    int           m_ptr   = 0;
    int           last_acc = -1;

    always #5 clk = ~clk;

    assign in_data = {ch[3], ch[2], ch[1], ch[0]};

    rr_stream_mux #(
        .WIDTH (W),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    function automatic int pick(input logic [N-1:0] v, input int p);
        int start = p;
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        int   w;
        logic load;
        #1;
        if (rst) model_reset();
        load = !m_valid || out_ready;
        w = (load && !rst) ? pick(in_valid, m_ptr) : -1;
        chk("in_ready", 32'(in_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", out_data, m_data);
        chk("out_sel", 32'(out_sel), 32'(m_sel));
        @(posedge clk);
        last_acc = w;
        if (rst) begin
            model_reset();
        end else if (load) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = ch[w];
                m_sel   = w;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] rr_vals [N];
        int           exp_seq [5];

        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) ch[i] = $urandom;

        @(negedge clk);
        #1 chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        cycle();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", out_data, 32'd0);

        // Single requester
        in_valid  = 4'b0010;
        ch[1]     = 32'h0000F320;
        out_ready = 1'b1;
        #1 chk("single_in_ready", 32'(in_ready), 32'h2);
        cycle();
        in_valid = '0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'h0000F320);
        chk("single_sel", 32'(out_sel), 32'd1);

        // Reset while a beat is held under backpressure
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_sel", 32'(out_sel), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_data", out_data, 32'd0);

        // All channels requesting
        rr_vals[0] = 32'h00008001;
        rr_vals[1] = 32'hFFFFFFFF;
        rr_vals[2] = 32'h0000F320;
        rr_vals[3] = 32'h00000000;
        for (int i = 0; i < N; i++) ch[i] = rr_vals[i];
        in_valid  = 4'b1111;
        out_ready = 1'b1;
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_sel", 32'(out_sel), 32'(exp_seq[k]));
            chk("rr_data", out_data, rr_vals[exp_seq[k]]);
        end

`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
        cycle();
        cycle();
        chk("bp_start_sel", 32'(out_sel), 32'd2);
        out_ready = 1'b0;
        repeat (3) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
            chk("bp_data", out_data, 32'h0000F320);
            chk("bp_sel", 32'(out_sel), 32'd2);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h8);
        cycle();
        chk("bp_next_sel", 32'(out_sel), 32'd3);
        chk("bp_next_data", out_data, 32'd0);

        // Pointer to 3, then wrap past channel 3 and skip channel 1
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0101;
        #1 chk("wrap_ready", 32'(in_ready), 32'h1);
        cycle();
        chk("wrap_sel", 32'(out_sel), 32'd0);
        chk("wrap_data", out_data, 32'h00008001);
        in_valid = 4'b0100;
        #1 chk("skip_ready", 32'(in_ready), 32'h4);
        cycle();
        chk("skip_sel", 32'(out_sel), 32'd2);
`endif

        // Randomized traffic respecting the hold-until-accepted rule
        in_valid = '0;
        cycle();
        for (int c = 0; c < 3000; c++) begin
            if (last_acc >= 0) in_valid[last_acc] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && ($urandom_range(2, 0) != 0)) begin
                    in_valid[i] = 1'b1;
                    ch[i]       = $urandom;
                end
            end
            out_ready = ($urandom_range(3, 0) != 0);
            rst       = ($urandom_range(199, 0) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
